rib_arbiter: RTL
================

# rib_arbiter

Registered round-robin arbiter and transaction watchdog for the RIB interconnect. It replaces the interconnect's combinational fixed-priority grant logic. It owns the grant for the three RIB masters (m0 execute/mem, m1 instruction fetch, m2 debug/JTAG) and locks each grant until the addressed slave acks. It aborts transactions that hit an unmapped slave nibble or exceed a cycle budget, and reports the abort as a one-cycle error pulse to the offending master. The interconnect consumes `grant_o`/`grant_valid_o` as its mux select.

## Interface
- `NUM_MASTERS`, 3: number of requesters; fixed at 3 in this revision.
- `NUM_SLAVES`, 5: mapped slave nibbles are 0 .. NUM_SLAVES-1.
- `TIMEOUT_CYCLES`, 255: maximum BUSY cycles without ack before abort.
- `CNT_W`, 8: watchdog counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `req_i`  in  3  per-master request; bit i is master i.
- `slv_sel_i`  in  12  address[31:28] of each master; master i occupies bits [4i+3:4i].
- `ack_i`  in  1  ack of the slave currently selected by the interconnect.
- `grant_o`  out  2  index of the granted master; reset 2'd1.
- `grant_valid_o`  out  1  grant is live and the slave path is enabled; reset 0.
- `err_o`  out  3  one-cycle abort pulse to master i; reset 0.
- `hold_flag_o`  out  1  pipeline stall request to the core; reset 0.

## Operation
- State machine states: IDLE, BUSY, ERR. Reset state is IDLE.
- **IDLE**
  - If `|req_i` is low, stay in IDLE.
  - Otherwise pick a winner by round-robin. Search order is last+1, last+2, last (mod 3), where `last` is the previous winner. `last` resets to 2, so first-time priority is 0, 1, 2.
  - Register the winner into `grant_o` and update `last`.
  - If the winner's slave nibble is >= NUM_SLAVES, go to ERR. Otherwise go to BUSY.
- **BUSY**
  - `grant_valid_o` = 1 and the watchdog counter increments each cycle.
  - `ack_i`=1 → IDLE and clear the counter.
  - `req_i[grant_o]`=0 before ack (master withdrew) → IDLE, no error.
  - Counter reaches TIMEOUT_CYCLES-1 with no ack → ERR.
  - If ack and timeout occur in the same cycle, ack wins.
- **ERR**
  - Lasts exactly one cycle.
  - `err_o[grant_o]` = 1, `grant_valid_o` = 0.
  - Then → IDLE; the counter clears.
- `hold_flag_o` = `req_i[0] | req_i[2]`, computed combinationally and gated low while `rst` is high. Master 1 (fetch) never stalls the pipeline.
- The `grant_o` value is held in IDLE and ERR. The interconnect must qualify every use of `grant_o` with `grant_valid_o`.
- Counter arithmetic is unsigned CNT_W bits and saturates; it never wraps.

## Timing
- Request at cycle N in IDLE → `grant_valid_o` = 1 at N+1.
- Ack sampled at cycle M → `grant_valid_o` = 0 at M+1; the next grant can be live at M+2. There is one dead cycle between back-to-back transactions.
- Unmapped-slave request at N → `err_o` pulse at N+1 → IDLE at N+2. `grant_valid_o` stays 0 throughout.
- Timeout: grant at G → `err_o` pulse at G+TIMEOUT_CYCLES.
- `rst` high mid-transaction: all outputs return to their reset values the next cycle, and the in-flight transaction is dropped silently with no `err_o`.

## Structure
- Shared package `rib_pkg`:
  - grant encodings GRANT0..GRANT2;
  - state enum {IDLE, BUSY, ERR};
  - slave nibble constants SLAVE_0..SLAVE_4;
  - RIB_ACK/RIB_NACK.
- The interconnect imports the same package.
- One combinational sub-module, `rib_rr_pick`: inputs `req`[2:0] and `last`[1:0]; outputs `winner`[1:0] and `any`.

## Test plan
- Reset, then `req_i`=3'b111 with ack one cycle after each grant → grant sequence 0, 1, 2, 0, with one dead cycle between grants.
- Only `req_i[1]` set, ack after 3 cycles → `grant_o`=1, `grant_valid_o` high for 3 cycles, `hold_flag_o`=0 throughout.
- `req_i[0]` with `slv_sel_i[3:0]`=4'h7 → `err_o`=3'b001 for one cycle at N+1, `grant_valid_o` never high.
- `req_i[2]` to slave 3, no ack, TIMEOUT_CYCLES=16 → `err_o`=3'b100 exactly 16 cycles after the grant, then a new grant for a pending requester.
- Ack arriving in the same cycle the counter hits the limit → no `err_o`; normal return to IDLE.
- `rst` pulsed while BUSY on master 2 → next cycle `grant_o`=1, `grant_valid_o`=0, `err_o`=0, `last`=2.

Source files
------------

// File: rtl/rib_pkg.sv
// rib_pkg: shared RIB interconnect encodings
package rib_pkg;
    localparam logic [1:0] GRANT0 = 2'd0;
    localparam logic [1:0] GRANT1 = 2'd1;
    localparam logic [1:0] GRANT2 = 2'd2;
    typedef enum logic [1:0] {IDLE, BUSY, ERR} state_e;
    localparam logic [3:0] SLAVE_0 = 4'h0;
    localparam logic [3:0] SLAVE_1 = 4'h1;
    localparam logic [3:0] SLAVE_2 = 4'h2;
    localparam logic [3:0] SLAVE_3 = 4'h3;
    localparam logic [3:0] SLAVE_4 = 4'h4;
    localparam logic RIB_ACK  = 1'b1;
    localparam logic RIB_NACK = 1'b0;
endpackage

// File: rtl/rib_rr_pick.sv
// rib_rr_pick: three-way round-robin winner search starting after the last winner
module rib_rr_pick (
    input  logic [2:0] req,
    input  logic [1:0] last,
    output logic [1:0] winner,
    output logic       any
);
    logic [1:0] lst, c1, c2;
    // search last+1, last+2, then last itself; an illegal last is treated as 2
    always_comb begin
        lst    = (last == 2'd3) ? 2'd2 : last;
        c1     = (lst == 2'd0) ? 2'd1 : (lst == 2'd1) ? 2'd2 : 2'd0;
        c2     = (lst == 2'd0) ? 2'd2 : (lst == 2'd1) ? 2'd0 : 2'd1;
        winner = req[c1] ? c1 : req[c2] ? c2 : lst;
        any    = |req;
    end
endmodule

// File: rtl/rib_arbiter.sv
// rib_arbiter: registered round-robin RIB grant with unmapped-slave and timeout abort
module rib_arbiter
    import rib_pkg::*;
#(
    parameter int NUM_MASTERS    = 3,
    parameter int NUM_SLAVES     = 5,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_MASTERS-1:0]   req_i,
    input  logic [4*NUM_MASTERS-1:0] slv_sel_i,
    input  logic                     ack_i,
    output logic [1:0]               grant_o,
    output logic                     grant_valid_o,
    output logic [NUM_MASTERS-1:0]   err_o,
    output logic                     hold_flag_o
);
    state_e           state_q, state_d;
    logic [1:0]       grant_q, grant_d, last_q, last_d, winner;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       nib;
    logic             any;

    rib_rr_pick u_pick (.req(req_i), .last(last_q), .winner(winner), .any(any));

    assign nib           = slv_sel_i[{winner, 2'b00} +: 4];
    assign grant_o       = grant_q;
    assign grant_valid_o = state_q == BUSY;
    assign err_o         = (state_q == ERR) ? NUM_MASTERS'(1) << grant_q : '0;
    assign hold_flag_o   = !rst && (req_i[0] || req_i[2]);

    // next state: ack beats withdraw beats timeout; counter only runs in BUSY
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = '0;
        case (state_q)
            IDLE: if (any) begin
                grant_d = winner;
                last_d  = winner;
                state_d = (32'(nib) >= NUM_SLAVES) ? ERR : BUSY;
            end
            BUSY: begin
                cnt_d   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
                state_d = (ack_i == RIB_ACK) ? IDLE :
                          !req_i[grant_q] ? IDLE :
                          (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) ? ERR : BUSY;
            end
            default: state_d = IDLE;
        endcase
        if (state_d != BUSY) cnt_d = '0;
    end

    // state registers; reset drops any in-flight transaction silently
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= GRANT1;
            last_q  <= GRANT2;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule
